// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam int DEFAULT_PACKET_WIDTH = 8;
  localparam int FRAME_BITS = 11;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, first request at or above ptr
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [$clog2(NUM_SRC)-1:0] idx,
  output logic                       valid
);

  localparam int IW = $clog2(NUM_SRC);

  logic [IW-1:0] j;

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_SRC);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one uart_encode among packet sources
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int PACKET_WIDTH   = DEFAULT_PACKET_WIDTH,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                              clk_baud,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                src_req,
  input  logic [NUM_SRC*PACKET_WIDTH*8-1:0] src_packet,
  output logic [NUM_SRC-1:0]                src_ack,
  output logic [NUM_SRC-1:0]                src_sent,
  output logic [PACKET_WIDTH*8-1:0]         enc_packet,
  output logic                              enc_ready,
  input  logic                              enc_done,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int PW = PACKET_WIDTH * 8;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  // A zero gap still costs one GAP cycle so the encoder sees ready low.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] cur, rr_ptr, arb_idx;
  logic          arb_valid, armed;
  logic [WW-1:0] wd;
  logic [3:0]    gap_cnt;
  logic          done_ok, wd_hit;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req   (src_req),
    .ptr   (rr_ptr),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // done is stale-high from the last packet until the encoder sees ready; only
  // a rising done after a sampled low counts as completion.
  assign done_ok = armed && enc_done;
  assign wd_hit  = (wd == WD_MAX);

  always_comb begin
    state_nxt   = state;
    src_ack     = '0;
    src_sent    = '0;
    enc_ready   = 1'b0;
    err_timeout = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: if (arb_valid) state_nxt = LOAD;
      LOAD: begin
        src_ack[cur] = 1'b1;
        state_nxt    = SEND;
      end
      SEND: begin
        enc_ready = 1'b1;
        if (done_ok) begin
          src_sent[cur] = 1'b1;
          state_nxt     = GAP;
        end else if (wd_hit) begin
          err_timeout = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_baud) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur        <= '0;
      enc_packet <= '0;
      armed      <= 1'b0;
      wd         <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (arb_valid) cur <= arb_idx;
        LOAD: begin
          enc_packet <= src_packet[int'(cur)*PW +: PW];
          rr_ptr     <= (cur == IW'(NUM_SRC - 1)) ? '0 : cur + 1'b1;
          armed      <= 1'b0;
          wd         <= '0;
        end
        SEND: begin
          if (!enc_done) armed <= 1'b1;
          if (!wd_hit) wd <= wd + 1'b1;
          gap_cnt <= '0;
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler with a behavioural encoder
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NS = 4;
  localparam int ENC_LEN = FRAME_BITS / 2;
  localparam int EV_ACK = 0, EV_SENT = 1, EV_TO = 2;

  typedef struct {
    int          kind;
    int          src;
    logic [63:0] data;
    int          cnt;
    int          lat;
  } ev_t;

  logic            clk_baud = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_req;
  logic [NS*64-1:0] src_packet;
  logic [NS-1:0]   src_ack, src_sent;
  logic [63:0]     enc_packet;
  logic            enc_ready, enc_done, busy, err_timeout;

  ev_t   q[$];
  int    nchk = 0, nfail = 0;
  int    cyc = 0, last_cyc = 0, rcnt = 0;
  bit    chk_low = 0, hang = 0, corrupt0 = 0;
  logic [NS-1:0] cont;

  uart_tx_scheduler #(
    .NUM_SRC(NS), .PACKET_WIDTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_baud(clk_baud), .rst_n(rst_n), .src_req(src_req), .src_packet(src_packet),
    .src_ack(src_ack), .src_sent(src_sent), .enc_packet(enc_packet),
    .enc_ready(enc_ready), .enc_done(enc_done), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk_baud = ~clk_baud;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input byte_t base);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = base + byte_t'(b);
    return v;
  endfunction

  task automatic set_pkt(input int s, input logic [63:0] v);
    src_packet[s*64 +: 64] = v;
  endtask

  task automatic push(input int kind, input int src, input logic [63:0] data,
                      input int cnt, input int lat);
    ev_t e;
    e.kind = kind; e.src = src; e.data = data; e.cnt = cnt; e.lat = lat;
    q.push_back(e);
  endtask

  // Encoder model: done stays stale-high for two ready cycles, drops, then
  // rises ENC_LEN cycles later unless hung; done is sticky while ready is low.
  initial begin
    int r = 0;
    enc_done = 1'b1;
    forever begin
      @(negedge clk_baud);
      if (enc_ready) r++; else r = 0;
      if (r == 3) enc_done = 1'b0;
      else if (r == 3 + ENC_LEN && !hang) enc_done = 1'b1;
    end
  end

  task automatic pop_check(input int kind, input logic [NS-1:0] vec);
    ev_t e;
    if (q.size() == 0) begin
      nchk++; nfail++;
      $display("FAIL unexpected_event kind=%0d actual=%b required=none", kind, vec);
    end else begin
      e = q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_src", 64'(vec), 64'(1) << e.src);
      if (kind != EV_ACK) check("ready_cycles", 64'(rcnt), 64'(e.cnt));
      if (kind == EV_SENT) check("sent_data", enc_packet, e.data);
      if (e.lat >= 0) check("event_spacing", 64'(cyc - last_cyc), 64'(e.lat));
    end
    last_cyc = cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk_baud);
      #1;
      cyc++;
      if (!rst_n) begin
        rcnt = 0;
        chk_low = 0;
      end else begin
        if (chk_low) begin
          check("ready_drop", 64'(enc_ready), 64'(0));
          chk_low = 0;
        end
        if (enc_ready) rcnt++; else rcnt = 0;
        if (|src_ack) pop_check(EV_ACK, src_ack);
        if (|src_sent) begin pop_check(EV_SENT, src_sent); chk_low = 1; end
        if (err_timeout) begin pop_check(EV_TO, 4'(1 << int'(dut.cur))); chk_low = 1; end
      end
    end
  end

  task automatic wait_idle(input int stop_after);
    int acks = 0;
    bit ok = 0, arm_corrupt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_baud);
      #2;
      if (arm_corrupt) begin set_pkt(0, '1); arm_corrupt = 0; end
      if (err_timeout) hang = 0;
      if (|src_ack) begin
        acks++;
        if (corrupt0 && src_ack[0]) begin arm_corrupt = 1; corrupt0 = 0; end
        src_req = src_req & ~(src_ack & ~cont);
        if (stop_after != 0 && acks == stop_after) begin cont = '0; src_req = '0; end
      end
      if (q.size() == 0 && !busy && src_req == '0 && !arm_corrupt) begin ok = 1; break; end
    end
    check("drain_done", 64'(ok), 64'(1));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; src_req = '0; src_packet = '0; cont = '0;
    repeat (3) @(negedge clk_baud);
    #2;
    check("rst_enc_ready", 64'(enc_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_src_ack", 64'(src_ack), 64'(0));
    check("rst_src_sent", 64'(src_sent), 64'(0));
    check("rst_err_timeout", 64'(err_timeout), 64'(0));
    check("rst_enc_packet", enc_packet, 64'(0));
    @(negedge clk_baud);
    rst_n = 1'b1;

    // Single request from source 2
    set_pkt(2, mk(8'h10));
    push(EV_ACK, 2, '0, 0, -1);
    push(EV_SENT, 2, mk(8'h10), 3 + ENC_LEN, -1);
    @(negedge clk_baud);
    src_req = 4'b0100;
    @(negedge clk_baud);
    #2;
    check("ack_latency", 64'(src_ack), 64'(4'b0100));
    src_req = '0;
    wait_idle(0);

    // All four requesting continuously from reset
    @(negedge clk_baud);
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) set_pkt(i, mk(byte_t'(8'h20 + 8'h10 * i)));
    src_req = 4'b1111; cont = 4'b1111;
    @(negedge clk_baud);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(EV_ACK, k % NS, '0, 0, (k == 0) ? -1 : 4);
      push(EV_SENT, k % NS, mk(byte_t'(8'h20 + 8'h10 * (k % NS))), 3 + ENC_LEN, -1);
    end
    wait_idle(6);

    // Serve 3 alone, then 1 and 3 together: pointer wraps to 0, so 1 goes first
    set_pkt(3, mk(8'h90)); set_pkt(1, mk(8'hA0));
    push(EV_ACK, 3, '0, 0, -1);
    push(EV_SENT, 3, mk(8'h90), 3 + ENC_LEN, -1);
    src_req = 4'b1000;
    wait_idle(0);
    push(EV_ACK, 1, '0, 0, -1);
    push(EV_SENT, 1, mk(8'hA0), 3 + ENC_LEN, -1);
    push(EV_ACK, 3, '0, 0, 4);
    push(EV_SENT, 3, mk(8'h90), 3 + ENC_LEN, -1);
    src_req = 4'b1010;
    wait_idle(0);

    // Source 0 rewrites its packet one cycle after the ack
    set_pkt(0, mk(8'h80));
    corrupt0 = 1;
    push(EV_ACK, 0, '0, 0, -1);
    push(EV_SENT, 0, mk(8'h80), 3 + ENC_LEN, -1);
    src_req = 4'b0001;
    wait_idle(0);

    // Hung encoder on source 2, then source 3 is served
    set_pkt(2, mk(8'hB0)); set_pkt(3, mk(8'hC0));
    hang = 1;
    push(EV_ACK, 2, '0, 0, -1);
    push(EV_TO, 2, '0, 101, -1);
    push(EV_ACK, 3, '0, 0, 4);
    push(EV_SENT, 3, mk(8'hC0), 3 + ENC_LEN, -1);
    src_req = 4'b1100;
    wait_idle(0);

    // Reset in the middle of source 1's packet
    set_pkt(1, mk(8'h50)); set_pkt(3, mk(8'h70));
    push(EV_ACK, 1, '0, 0, -1);
    src_req = 4'b1010;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk_baud);
      #2;
      if (src_ack[1]) begin seen = 1; src_req[1] = 1'b0; end
    end
    check("mid_ack_seen", 64'(seen), 64'(1));
    repeat (4) @(negedge clk_baud);
    rst_n = 1'b0;
    @(posedge clk_baud);
    #1;
    check("mid_rst_enc_ready", 64'(enc_ready), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    @(negedge clk_baud);
    rst_n = 1'b1;
    set_pkt(1, mk(8'h60));
    src_req[1] = 1'b1;
    push(EV_ACK, 1, '0, 0, -1);
    push(EV_SENT, 1, mk(8'h60), 3 + ENC_LEN, -1);
    push(EV_ACK, 3, '0, 0, 4);
    push(EV_SENT, 3, mk(8'h70), 3 + ENC_LEN, -1);
    wait_idle(0);

    repeat (3) @(negedge clk_baud);
    check("queue_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
